// File: rtl/player_action_encoder_if.sv
// Button/tick inputs and action outputs of one player's action encoder.
interface player_action_encoder_if;
  logic [5:0] btn;
  logic       tick;
  logic [5:0] action;
  logic       action_stb;
  logic       cooldown;

  // Stimulus side: drives buttons and the game tick, observes actions.
  modport master (output btn, tick, input action, action_stb, cooldown);
  // Encoder side.
  modport slave  (input btn, tick, output action, action_stb, cooldown);
endinterface

// File: rtl/player_action_encoder.sv
// Player action encoder: sync + debounce every button, capture press edges,
// and on each game tick issue at most one one-hot action to the player FSM.

// One button lane: 2-flop synchronizer and counter debouncer.
// flip is high in the cycle whose posedge will move stable to the synced level.
module player_action_db #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic stable,
  output logic flip
);
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;
  logic            differ;

  assign differ = sync[1] ^ stable;
  assign flip   = differ && (cnt == CNT_MAX);

  // Synchronize, then only accept a new level after DB_CYCLES differing cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module player_action_encoder #(
  parameter int DB_CYCLES    = 4,
  parameter int DB_W         = 3,
  parameter int ATK_COOLDOWN = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  player_action_encoder_if.slave  bus
);
  localparam int NUM_BTN = 6;
  localparam int CD_W    = (ATK_COOLDOWN > 0) ? $clog2(ATK_COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(ATK_COOLDOWN);
  // W (bit 2) is level-requested, every other button is edge-requested.
  localparam logic [NUM_BTN-1:0] EDGE_MASK = 6'b111011;

  logic [NUM_BTN-1:0] stable, flip, rise, pending, req, winner;
  logic [NUM_BTN-1:0] act;
  logic               stb;
  logic [CD_W-1:0]    cd_cnt;

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      player_action_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
        .CLK    (CLK),
        .RST    (RST),
        .raw    (bus.btn[i]),
        .stable (stable[i]),
        .flip   (flip[i])
      );
    end
  endgenerate

  // A flip while stable is still 0 is a debounced press arriving this cycle.
  assign rise = flip & ~stable & EDGE_MASK;

  // Request set for this tick: cancel opposing moves, mask attacks in cooldown.
  always_comb begin
    req    = pending | rise;
    req[2] = stable[2];
    if (req[4] && req[3]) begin
      req[4] = 1'b0;
      req[3] = 1'b0;
    end
    if (cd_cnt != '0) req[1:0] = 2'b00;
  end

  // Fixed priority J > P > K > ML > MR > W.
  always_comb begin
    winner = '0;
    if      (req[5]) winner[5] = 1'b1;
    else if (req[1]) winner[1] = 1'b1;
    else if (req[0]) winner[0] = 1'b1;
    else if (req[3]) winner[3] = 1'b1;
    else if (req[4]) winner[4] = 1'b1;
    else if (req[2]) winner[2] = 1'b1;
  end

  // Tick: register winner, drop all pending, run cooldown; else collect edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
      cd_cnt  <= '0;
      act     <= '0;
      stb     <= 1'b0;
    end else if (bus.tick) begin
      act     <= winner;
      stb     <= |winner;
      pending <= '0;
      if (winner[1] || winner[0]) cd_cnt <= CD_LOAD;
      else if (cd_cnt != '0)      cd_cnt <= cd_cnt - 1'b1;
    end else begin
      act     <= '0;
      stb     <= 1'b0;
      pending <= pending | rise;
    end
  end

  assign bus.action     = act;
  assign bus.action_stb = stb;
  assign bus.cooldown   = (cd_cnt != '0);
endmodule
